// File: rtl/decoder_scan_nxm_if.sv
// Bus bundle for decoder_scan_nxm: control/select inputs plus the registered
// decoded lines, index and wrap pulse.
interface decoder_scan_nxm_if #(
    parameter int SEL_W = 2
);
    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  load;
    logic [(2**SEL_W)-1:0] D;
    logic [SEL_W-1:0]      idx;
    logic                  wrap;

    modport master (
        output en, mode, sel, load,
        input  D, idx, wrap
    );

    modport slave (
        input  en, mode, sel, load,
        output D, idx, wrap
    );
endinterface

// File: rtl/decoder_scan_nxm.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with enable, selectable output
// polarity and a round-robin SCAN mode that dwells DWELL cycles per line.
module decoder_scan_nxm #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic               clk,
    input logic               rst,
    decoder_scan_nxm_if.slave bus
);
    localparam int N  = 2**SEL_W;
    localparam int CW = $clog2(DWELL) + 1;

    localparam logic [CW-1:0]    LAST_CNT = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic [N-1:0]     ONE      = N'(1);
    localparam logic [N-1:0]     INACTIVE = ACTIVE_LOW ? '1 : '0;

    typedef enum logic {DIRECT, SCAN} state_t;

    state_t           state;
    logic [CW-1:0]    dwell_cnt;
    logic [SEL_W-1:0] idx_q;
    logic [N-1:0]     d_q;
    logic             wrap_q;

    logic [SEL_W-1:0] nidx;
    logic [CW-1:0]    ncnt;
    logic             nwrap;
    logic [N-1:0]     onehot;

    // Only a settled SCAN state (not the entry edge) can hold, advance or load;
    // every other case reloads the index from sel with a fresh dwell count.
    always_comb begin
        nidx  = bus.sel;
        ncnt  = '0;
        nwrap = 1'b0;
        if (bus.mode && state == SCAN && !bus.load) begin
            if (!bus.en) begin
                nidx = idx_q;
                ncnt = dwell_cnt;
            end else if (dwell_cnt == LAST_CNT) begin
                nidx  = idx_q + 1'b1;
                nwrap = (idx_q == LAST_IDX);
            end else begin
                nidx = idx_q;
                ncnt = dwell_cnt + 1'b1;
            end
        end
        onehot = ONE << nidx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIRECT;
            dwell_cnt <= '0;
            idx_q     <= '0;
            d_q       <= INACTIVE;
            wrap_q    <= 1'b0;
        end else begin
            state     <= bus.mode ? SCAN : DIRECT;
            dwell_cnt <= ncnt;
            idx_q     <= nidx;
            wrap_q    <= nwrap;
            if (!bus.en)
                d_q <= INACTIVE;
            else
                d_q <= ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    assign bus.D    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule
